boot_copy_ctrl: RTL and testbench

//  Sequences data_bus for the boot image copy: byte-reads from flash (`FLASH_INIT region),

---
 rtl/boot_copy_ctrl_pkg.sv | 31 +++
 rtl/boot_copy_ctrl_step_tick_gen.sv | 49 ++++
 rtl/boot_copy_ctrl.sv | 159 +++++++++++++++
 tb/tb_boot_copy_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_copy_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : boot_copy_ctrl_pkg                                     |
// | Description : Shared memory map, data_bus length encodings and copy  |
// |               FSM state encodings for the boot image copy controller.|
// | Revision    : 1.0 - single-clock tick-enabled copy sequencer         |
// +----------------------------------------------------------------------+
package boot_copy_ctrl_pkg;

  // Memory map: boot image lives in flash, is executed from RAM.
  localparam logic [31:0] c_flash_init = 32'h1000_0000;
  localparam logic [31:0] c_ram_init   = 32'h2000_0000;

  // data_bus length encoding; the copy engine only ever moves bytes.
  localparam logic [1:0]  c_len_byte   = 2'b00;

  // Copy FSM state encoding (3-bit, legacy-compatible constants).
  localparam logic [2:0]  c_st_idle    = 3'd0;
  localparam logic [2:0]  c_st_read    = 3'd1;
  localparam logic [2:0]  c_st_write   = 3'd2;
  localparam logic [2:0]  c_st_done    = 3'd3;
  localparam logic [2:0]  c_st_err     = 3'd4;

  // The copy engine owns data_bus (and the CPU is blocked) only while
  // it is actively reading or writing.
  function automatic logic is_copy_state(input logic [2:0] st);
    return (st == c_st_read) || (st == c_st_write);
  endfunction

endpackage
`default_nettype wire

// File: rtl/boot_copy_ctrl_step_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : boot_copy_ctrl_step_tick_gen                           |
// | Description : Produces a one-cycle step enable every STEP_DIV+1      |
// |               clocks while enabled. Replaces a divided clock so the  |
// |               whole copy path stays on clk.                          |
// | Revision    : 1.0 - initial                                          |
// +----------------------------------------------------------------------+
module boot_copy_ctrl_step_tick_gen #(
  parameter int unsigned STEP_DIV = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  generate
    if (STEP_DIV == 0) begin : g_every_cycle
      // No division: every enabled cycle is a step, no counter needed.
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst_n, clr};
      assign tick          = en;
    end else begin : g_divided
      localparam int unsigned      c_cnt_w = $clog2(STEP_DIV + 1);
      localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(STEP_DIV);

      logic [c_cnt_w-1:0] r_cnt;

      // Phase counter: held at zero when idle or restarted, wraps on each step.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (clr || !en) begin
          r_cnt <= '0;
        end else if (r_cnt == c_last) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end

      assign tick = en && (r_cnt == c_last);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/boot_copy_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : boot_copy_ctrl                                         |
// | Description : Boot image copy sequencer. Byte-copies COPY_LEN bytes  |
// |               from flash to RAM over data_bus, then hands data_bus   |
// |               to the CPU port. Sits between the CPU and data_bus.    |
// | Revision    : 1.0 - single-clock tick-enabled FSM                    |
// +----------------------------------------------------------------------+
module boot_copy_ctrl
  import boot_copy_ctrl_pkg::*;
#(
  parameter logic [31:0] SRC_BASE   = c_flash_init,
  parameter logic [31:0] DST_BASE   = c_ram_init,
  parameter int unsigned COPY_LEN   = 261,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned STEP_DIV   = 0,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  // copy control / status
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] err_addr,
  // CPU side
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [1:0]  cpu_len,
  input  logic [31:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_exc,
  // data_bus side
  output logic        bus_rw,
  output logic [1:0]  bus_len,
  output logic [31:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_exc
);

  // Index of the final byte; a zero-length copy never reaches the compare.
  localparam logic [CNT_W-1:0] c_last_idx =
    CNT_W'((COPY_LEN == 0) ? 0 : (COPY_LEN - 1));

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_idx;
  logic [7:0]       r_data_q;
  logic             r_done;
  logic             r_error;
  logic [31:0]      r_err_addr;
  logic             r_auto_pend;

  logic             w_busy;
  logic             w_start;
  logic             w_tick;
  logic [31:0]      w_copy_addr;

  assign w_busy  = is_copy_state(r_state);

  // A pending auto-start behaves exactly like a start pulse on the first
  // edge after reset release; starts are only honoured when not copying.
  assign w_start = (start || r_auto_pend) && !w_busy;

  // Reads walk the source window, writes the destination window; the
  // 32-bit add wraps naturally at the top of the address space.
  assign w_copy_addr = ((r_state == c_st_write) ? DST_BASE : SRC_BASE)
                       + 32'(r_idx);

  boot_copy_ctrl_step_tick_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_step_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_busy),
    .clr   (w_start),
    .tick  (w_tick)
  );

  // Copy sequencer: start handling, read/write alternation, exception abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_idx       <= '0;
      r_data_q    <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_addr  <= '0;
      r_auto_pend <= AUTO_START;
    end else begin
      r_auto_pend <= 1'b0;
      if (w_start) begin
        r_idx   <= '0;
        r_error <= 1'b0;
        if (COPY_LEN == 0) begin
          r_state <= c_st_done;
          r_done  <= 1'b1;
        end else begin
          r_state <= c_st_read;
          r_done  <= 1'b0;
        end
      end else if (w_busy && w_tick) begin
        if (bus_exc) begin
          // An exception beats completion, even on the final write.
          r_state    <= c_st_err;
          r_error    <= 1'b1;
          r_err_addr <= w_copy_addr;
        end else if (r_state == c_st_read) begin
          r_data_q <= bus_rdata;
          r_state  <= c_st_write;
        end else if (r_idx == c_last_idx) begin
          r_state <= c_st_done;
          r_done  <= 1'b1;
        end else begin
          r_idx   <= r_idx + CNT_W'(1);
          r_state <= c_st_read;
        end
      end
    end
  end

  // data_bus ownership: copy engine while busy, otherwise a granted CPU,
  // otherwise a quiet all-zero bus.
  always_comb begin
    bus_rw    = 1'b0;
    bus_len   = 2'b00;
    bus_addr  = '0;
    bus_wdata = '0;
    cpu_gnt   = cpu_req && !w_busy;
    cpu_rdata = '0;
    cpu_exc   = 1'b0;
    if (r_state == c_st_read) begin
      bus_len  = c_len_byte;
      bus_addr = w_copy_addr;
    end else if (r_state == c_st_write) begin
      bus_rw    = 1'b1;
      bus_len   = c_len_byte;
      bus_addr  = w_copy_addr;
      bus_wdata = r_data_q;
    end else if (cpu_gnt) begin
      bus_rw    = cpu_rw;
      bus_len   = cpu_len;
      bus_addr  = cpu_addr;
      bus_wdata = cpu_wdata;
      cpu_rdata = bus_rdata;
      cpu_exc   = bus_exc;
    end
  end

  assign busy     = w_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign err_addr = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_boot_copy_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_boot_copy_ctrl                                      |
// | Description : Self-checking bench for boot_copy_ctrl: a 4-byte       |
// |               auto-start copy instance with a flash/RAM model, and   |
// |               a divided-step instance that crosses the 2**32 wrap.   |
// | Revision    : 1.0 - initial                                          |
// +----------------------------------------------------------------------+
module tb_boot_copy_ctrl;
  import boot_copy_ctrl_pkg::*;

  localparam logic [31:0] c_src  = c_flash_init;
  localparam logic [31:0] c_dst  = c_ram_init;
  localparam int          c_len  = 4;
  localparam logic [31:0] c_src2 = 32'hFFFF_FFFF;
  localparam logic [31:0] c_dst2 = 32'h0000_0100;
  localparam logic [7:0]  c_fill = 8'h5A;

  int tests_run    = 0;
  int tests_failed = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, busy, done, error;
  logic [31:0] err_addr;
  logic        cpu_req, cpu_rw, cpu_gnt, cpu_exc;
  logic [1:0]  cpu_len;
  logic [31:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        bus_rw, bus_exc;
  logic [1:0]  bus_len;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;

  logic        start2, busy2, done2, error2, cpu_gnt2, cpu_exc2, bus_rw2;
  logic [31:0] err_addr2, bus_addr2;
  logic [7:0]  cpu_rdata2, bus_wdata2, bus_rdata2;
  logic [1:0]  bus_len2;

  // ---------------- memory model for instance 1 ----------------
  logic [7:0]  flash [0:c_len-1];
  logic [7:0]  ram   [0:c_len-1];
  logic        ram_clr;
  logic        exc_arm;
  wire  [31:0] src_off = bus_addr - c_src;
  wire  [31:0] dst_off = bus_addr - c_dst;

  function automatic logic [7:0] open_bus(input logic [31:0] a);
    return a[7:0] ^ 8'h96;
  endfunction

  always_comb begin
    if (src_off < 32'(c_len))      bus_rdata = flash[src_off[1:0]];
    else if (dst_off < 32'(c_len)) bus_rdata = ram[dst_off[1:0]];
    else                           bus_rdata = open_bus(bus_addr);
  end

  assign bus_exc = exc_arm && bus_rw && (bus_addr == c_dst + 32'd2);

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < c_len; i++) ram[i] <= c_fill;
    end else if (bus_rw && !bus_exc && (dst_off < 32'(c_len))) begin
      ram[dst_off[1:0]] <= bus_wdata;
    end
  end

  // Instance 2 sees a pure function of the address as its source data.
  assign bus_rdata2 = bus_addr2[7:0] ^ 8'h3C;

  boot_copy_ctrl #(
    .SRC_BASE(c_src), .DST_BASE(c_dst), .COPY_LEN(c_len), .CNT_W(16),
    .STEP_DIV(0), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .error(error), .err_addr(err_addr), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .cpu_len(cpu_len), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_exc(cpu_exc),
    .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_exc(bus_exc)
  );

  boot_copy_ctrl #(
    .SRC_BASE(c_src2), .DST_BASE(c_dst2), .COPY_LEN(2), .CNT_W(4),
    .STEP_DIV(2), .AUTO_START(1'b0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .error(error2), .err_addr(err_addr2), .cpu_req(1'b0), .cpu_rw(1'b0),
    .cpu_len(2'b00), .cpu_addr(32'h0), .cpu_wdata(8'h00),
    .cpu_gnt(cpu_gnt2), .cpu_rdata(cpu_rdata2), .cpu_exc(cpu_exc2),
    .bus_rw(bus_rw2), .bus_len(bus_len2), .bus_addr(bus_addr2),
    .bus_wdata(bus_wdata2), .bus_rdata(bus_rdata2), .bus_exc(1'b0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected copy address after the c-th edge of a STEP_DIV=0 copy.
  function automatic logic [31:0] copy_addr(input int c);
    int s = c - 1;
    return (((s % 2) == 0) ? c_src : c_dst) + 32'(s / 2);
  endfunction

  task automatic new_image();
    for (int i = 0; i < c_len; i++) flash[i] = 8'($urandom);
    ram_clr = 1'b1;
    tick();
    ram_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; cpu_req = 1'b0; cpu_rw = 1'b0;
    cpu_len = 2'b00; cpu_addr = '0; cpu_wdata = '0; ram_clr = 1'b0;
    exc_arm = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({busy, done, error} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_status: busy/done/error=%b want 000", {busy, done, error});
    end
    tests_run++;
    if (err_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_err_addr: got %h want 0", err_addr);
    end
    tests_run++;
    if ({bus_rw, bus_len, bus_addr, bus_wdata} !== 43'h0 || cpu_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_bus: rw=%b len=%b addr=%h gnt=%b want all 0",
               bus_rw, bus_len, bus_addr, cpu_gnt);
    end
    tests_run++;
    if ({busy2, done2, error2, bus_addr2} !== 35'h0) begin
      tests_failed++;
      $display("FAIL reset_dut2: busy=%b done=%b addr=%h want 0", busy2, done2, bus_addr2);
    end
  endtask

  task automatic test_auto_copy();
    flash[0] = 8'hA0; flash[1] = 8'hA1; flash[2] = 8'hA2; flash[3] = 8'hA3;
    ram_clr = 1'b1;
    tick();
    ram_clr = 1'b0;
    rst_n   = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      tests_run++;
      if (bus_addr !== copy_addr(c) || busy !== 1'b1 || done !== 1'b0 ||
          bus_rw !== 1'(((c - 1) % 2) == 1)) begin
        tests_failed++;
        $display("FAIL auto_step%0d: addr=%h rw=%b busy=%b done=%b want addr=%h",
                 c, bus_addr, bus_rw, busy, done, copy_addr(c));
      end
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL auto_done_cycle9: done=%b busy=%b error=%b want 1 0 0", done, busy, error);
    end
    for (int i = 0; i < c_len; i++) begin
      tests_run++;
      if (ram[i] !== 8'hA0 + 8'(i)) begin
        tests_failed++;
        $display("FAIL auto_ram%0d: got %h want %h", i, ram[i], 8'hA0 + 8'(i));
      end
    end
    tests_run++;
    if (busy2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_auto_dut2: busy=%b want 0", busy2);
    end
  endtask

  task automatic test_cpu_block_restart();
    new_image();
    cpu_addr = 32'hC000_1234; cpu_len = 2'b10; cpu_rw = 1'b0; cpu_req = 1'b1;
    start = 1'b1;
    #1;
    tests_run++;
    if (cpu_gnt !== 1'b1 || bus_addr !== cpu_addr || bus_len !== 2'b10 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_and_req: gnt=%b addr=%h len=%b done=%b want 1 %h 10 1",
               cpu_gnt, bus_addr, bus_len, done, cpu_addr);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      tests_run++;
      if (cpu_gnt !== 1'b0 || cpu_rdata !== 8'h00 || done !== 1'b0 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL cpu_blocked%0d: gnt=%b rdata=%h done=%b busy=%b want 0 00 0 1",
                 c, cpu_gnt, cpu_rdata, done, busy);
      end
    end
    tick();
    tests_run++;
    if (done !== 1'b1 || cpu_gnt !== 1'b1 || bus_addr !== cpu_addr ||
        cpu_rdata !== open_bus(cpu_addr)) begin
      tests_failed++;
      $display("FAIL cpu_after_done: done=%b gnt=%b addr=%h rdata=%h want 1 1 %h %h",
               done, cpu_gnt, bus_addr, cpu_rdata, cpu_addr, open_bus(cpu_addr));
    end
    for (int i = 0; i < c_len; i++) begin
      tests_run++;
      if (ram[i] !== flash[i]) begin
        tests_failed++;
        $display("FAIL restart_ram%0d: got %h want %h", i, ram[i], flash[i]);
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_start_ignored();
    new_image();
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = (c == 3 || c == 4);
      tests_run++;
      if (bus_addr !== copy_addr(c)) begin
        tests_failed++;
        $display("FAIL busy_start_step%0d: addr=%h want %h", c, bus_addr, copy_addr(c));
      end
    end
    start = 1'b0;
    tick();
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_start_done: done=%b busy=%b want 1 0", done, busy);
    end
  endtask

  task automatic test_exception();
    new_image();
    exc_arm = 1'b1;
    start   = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
      tests_run++;
      if (error !== 1'b0 || busy !== 1'b1 || bus_addr !== copy_addr(c)) begin
        tests_failed++;
        $display("FAIL exc_pre%0d: error=%b busy=%b addr=%h want 0 1 %h",
                 c, error, busy, bus_addr, copy_addr(c));
      end
    end
    tick();
    tests_run++;
    if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || err_addr !== c_dst + 32'd2) begin
      tests_failed++;
      $display("FAIL exc_abort: error=%b done=%b busy=%b err_addr=%h want 1 0 0 %h",
               error, done, busy, err_addr, c_dst + 32'd2);
    end
    repeat (3) tick();
    tests_run++;
    if (ram[0] !== flash[0] || ram[1] !== flash[1] || ram[2] !== c_fill ||
        ram[3] !== c_fill || bus_rw !== 1'b0) begin
      tests_failed++;
      $display("FAIL exc_ram: ram=%h %h %h %h rw=%b want %h %h %h %h 0",
               ram[0], ram[1], ram[2], ram[3], bus_rw, flash[0], flash[1], c_fill, c_fill);
    end
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = c_dst + 32'd2; cpu_wdata = 8'h77;
    #1;
    tests_run++;
    if (cpu_gnt !== 1'b1 || cpu_exc !== 1'b1 || error !== 1'b1) begin
      tests_failed++;
      $display("FAIL exc_to_cpu: gnt=%b exc=%b error=%b want 1 1 1", cpu_gnt, cpu_exc, error);
    end
    cpu_req = 1'b0; cpu_rw = 1'b0;
    exc_arm = 1'b0;
  endtask

  task automatic test_reset_mid_copy();
    new_image();
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_from_err: error=%b busy=%b want 0 1", error, busy);
    end
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, error} !== 3'b000 || err_addr !== 32'h0 ||
        {bus_rw, bus_addr, bus_wdata} !== 41'h0) begin
      tests_failed++;
      $display("FAIL async_reset: busy=%b done=%b error=%b err_addr=%h rw=%b addr=%h want all 0",
               busy, done, error, err_addr, bus_rw, bus_addr);
    end
    repeat (2) tick();
    new_image();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (bus_addr !== c_src || bus_rw !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_restart: addr=%h rw=%b busy=%b want %h 0 1",
               bus_addr, bus_rw, busy, c_src);
    end
    repeat (8) tick();
    tests_run++;
    if (done !== 1'b1 || ram[0] !== flash[0] || ram[3] !== flash[3]) begin
      tests_failed++;
      $display("FAIL reset_recopy: done=%b ram0=%h ram3=%h want 1 %h %h",
               done, ram[0], ram[3], flash[0], flash[3]);
    end
  endtask

  task automatic test_step_div();
    logic [31:0] exp_addr;
    start2 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      int s;
      tick();
      start2   = 1'b0;
      s        = (c - 1) / 3;
      exp_addr = (((s % 2) == 0) ? c_src2 : c_dst2) + 32'(s / 2);
      tests_run++;
      if (bus_addr2 !== exp_addr || busy2 !== 1'b1 || done2 !== 1'b0) begin
        tests_failed++;
        $display("FAIL div_step%0d: addr=%h busy=%b done=%b want %h 1 0",
                 c, bus_addr2, busy2, done2, exp_addr);
      end
      if ((s % 2) == 1) begin
        exp_addr = c_src2 + 32'(s / 2);
        tests_run++;
        if (bus_wdata2 !== (exp_addr[7:0] ^ 8'h3C) || bus_rw2 !== 1'b1) begin
          tests_failed++;
          $display("FAIL div_wdata%0d: data=%h rw=%b want %h 1",
                   c, bus_wdata2, bus_rw2, exp_addr[7:0] ^ 8'h3C);
        end
      end
    end
    tick();
    tests_run++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || bus_addr2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL div_done: done=%b busy=%b addr=%h want 1 0 0", done2, busy2, bus_addr2);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int it = 0; it < 5; it++) begin
      new_image();
      for (int k = 0; k < 4; k++) begin
        r = $urandom; cpu_addr = {4'hC, r[27:0]};
        r = $urandom; cpu_req = r[0]; cpu_rw = r[1]; cpu_len = r[3:2]; cpu_wdata = r[15:8];
        #1;
        tests_run++;
        if (cpu_gnt !== cpu_req ||
            (cpu_req && (bus_addr !== cpu_addr || bus_rw !== cpu_rw || bus_len !== cpu_len ||
                         bus_wdata !== cpu_wdata || cpu_rdata !== open_bus(cpu_addr))) ||
            (!cpu_req && (bus_addr !== 32'h0 || bus_rw !== 1'b0 || cpu_rdata !== 8'h00))) begin
          tests_failed++;
          $display("FAIL rand_idle%0d: req=%b gnt=%b addr=%h rw=%b rdata=%h cpu_addr=%h",
                   it, cpu_req, cpu_gnt, bus_addr, bus_rw, cpu_rdata, cpu_addr);
        end
        tick();
      end
      cpu_req = 1'b0;
      start   = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        tick();
        start = 1'b0;
        r = $urandom; cpu_req = r[0]; cpu_rw = r[1]; cpu_addr = {4'hC, r[31:4]};
        #1;
        tests_run++;
        if (cpu_gnt !== 1'b0 || cpu_rdata !== 8'h00 || bus_addr !== copy_addr(c)) begin
          tests_failed++;
          $display("FAIL rand_copy%0d_%0d: gnt=%b rdata=%h addr=%h want 0 00 %h",
                   it, c, cpu_gnt, cpu_rdata, bus_addr, copy_addr(c));
        end
      end
      cpu_req = 1'b0; cpu_rw = 1'b0;
      tick();
      tests_run++;
      if (done !== 1'b1 || ram[0] !== flash[0] || ram[1] !== flash[1] ||
          ram[2] !== flash[2] || ram[3] !== flash[3]) begin
        tests_failed++;
        $display("FAIL rand_result%0d: done=%b ram=%h %h %h %h want 1 %h %h %h %h", it, done,
                 ram[0], ram[1], ram[2], ram[3], flash[0], flash[1], flash[2], flash[3]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_auto_copy();
    test_cpu_block_restart();
    test_start_ignored();
    test_exception();
    test_reset_mid_copy();
    test_step_div();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
